// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops return one edge after accept, MUL runs a W-step shift-add.
// state | meaning
// IDLE  | no result held, ready for a request
// BUSY  | iterative multiply in progress
// DONE  | result held on Out until consumed
module alu_pipe #(
    parameter int W      = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         InValid,
    output logic         InReady,
    input  logic [W-1:0] InputA,
    input  logic [W-1:0] InputB,
    input  logic [3:0]   OP,
    input  logic         SC_in,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [W-1:0] Out,
    output logic         Zero,
    output logic         Parity,
    output logic         Odd,
    output logic         SC_out
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic             rdy_q;
    logic             accept;
    logic [W-1:0]     res;
    logic             res_sc;
    logic             is_mul;
    logic [W:0]       ext;
    logic [2*W-1:0]   sh;
    logic [2*W-1:0]   acc_q, acc_d, acc_step;
    logic [2*W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_iter;
    logic             load_en;
    logic [W-1:0]     load_val;
    logic             load_sc;
    logic [W-1:0]     out_q;
    logic             zero_q, par_q, odd_q, sc_q;

    always_comb begin
        res    = '0;
        res_sc = 1'b0;
        is_mul = 1'b0;
        ext    = '0;
        sh     = '0;
        case (OP)
            4'd0: begin
                ext    = {1'b0, InputA} + {1'b0, InputB};
                res    = ext[W-1:0];
                res_sc = ext[W];
            end
            4'd1: begin
                ext    = {1'b0, InputA} - {1'b0, InputB};
                res    = ext[W-1:0];
                res_sc = ext[W];
            end
            4'd2: res = InputA & InputB;
            4'd3: res = ~(InputA | InputB);
            4'd4: res = InputA ^ InputB;
            4'd5: begin
                // The bit just below the result window is the last one shifted out.
                sh     = {InputA, {W{1'b0}}} >> InputB;
                res    = sh[2*W-1:W];
                res_sc = sh[W-1];
            end
            4'd6: begin
                sh     = {{W{1'b0}}, InputA} << InputB;
                res    = sh[W-1:0];
                res_sc = sh[W];
            end
            4'd7:  res = {{(W-1){1'b0}}, InputA == InputB};
            4'd8:  res = {{(W-1){1'b0}}, InputA != InputB};
            4'd9:  res = {{(W-1){1'b0}}, InputA > InputB};
            4'd10: res = {{(W-1){1'b0}}, InputA < InputB};
            4'd11: begin
                ext    = {1'b0, InputA} + {1'b0, InputB} + {{W{1'b0}}, SC_in};
                res    = ext[W-1:0];
                res_sc = ext[W];
            end
            4'd12: is_mul = MUL_EN;
            default: ;
        endcase
    end

    assign InReady   = rdy_q && ((state_q == IDLE) || ((state_q == DONE) && OutReady));
    assign accept    = InValid && InReady;
    assign last_iter = (state_q == BUSY) && (cnt_q == CW'(1));
    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = is_mul ? BUSY : DONE;
            BUSY: if (last_iter) state_d = DONE;
            DONE: begin
                if (accept)        state_d = is_mul ? BUSY : DONE;
                else if (OutReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        OutValid = (state_q == DONE);
        Out      = out_q;
        Zero     = zero_q;
        Parity   = par_q;
        Odd      = odd_q;
        SC_out   = sc_q;
    end

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (accept && is_mul) begin
            acc_d    = '0;
            mcand_d  = {{W{1'b0}}, InputA};
            mplier_d = InputB;
            cnt_d    = CW'(W);
        end else if (state_q == BUSY) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
        end
    end

    always_comb begin
        load_en  = 1'b0;
        load_val = res;
        load_sc  = res_sc;
        if (accept && !is_mul) begin
            load_en = 1'b1;
        end else if (last_iter) begin
            load_en  = 1'b1;
            load_val = acc_step[W-1:0];
            load_sc  = |acc_step[2*W-1:W];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            zero_q   <= 1'b0;
            par_q    <= 1'b0;
            odd_q    <= 1'b0;
            sc_q     <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            if (load_en) begin
                out_q  <= load_val;
                zero_q <= (load_val == '0);
                par_q  <= ^load_val;
                odd_q  <= load_val[0];
                sc_q   <= load_sc;
            end
        end
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL take parameter W, default 8: operand/result width, W >= 4.
REQ-002 The block SHALL take parameter MUL_EN, default 1: enables iterative multiply (OP 12); when 0, OP 12 behaves as an undefined opcode.
REQ-003 The block SHALL have port Clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port InValid, input, 1 bit: operation request.
REQ-006 The block SHALL have port InReady, output, 1 bit: request accepted on an edge where InValid && InReady.
REQ-007 The block SHALL have port InputA, input, W bits: operand A.
REQ-008 The block SHALL have port InputB, input, W bits: operand B, also the shift amount.
REQ-009 The block SHALL have port OP, input, 4 bits: opcode.
REQ-010 The block SHALL have port SC_in, input, 1 bit: carry-in for ADDC.
REQ-011 The block SHALL have port OutValid, output, 1 bit: result valid.
REQ-012 The block SHALL have port OutReady, input, 1 bit: result consumed on an edge where OutValid && OutReady.
REQ-013 The block SHALL have port Out, output, W bits: registered result.
REQ-014 The block SHALL have ports Zero, Parity, Odd, SC_out, output, 1 bit each: registered flags for Out.

Function
REQ-015 The block SHALL implement these opcodes: 0 ADD A+B; 1 SUB A-B; 2 AND; 3 NOR; 4 XOR; 5 SHR logical A>>B; 6 SHL A<<B; 7 EQ; 8 NE; 9 GT unsigned; 10 LT unsigned; 11 ADDC A+B+SC_in; 12 MUL, low W bits of A*B; 13-15 give Out=0 and SC_out=0.
REQ-016 Compare ops SHALL return Out = {W-1 zeros, result bit}.
REQ-017 Shifts SHALL give Out=0 when B >= W.
REQ-018 Flags SHALL be computed from the registered Out: Zero = (Out==0), Parity = XOR-reduce(Out), Odd = Out[0].
REQ-019 SC_out SHALL be: carry-out for ADD/ADDC; borrow (A<B) for SUB; last bit shifted out for SHR/SHL (0 if B==0 or B>W); 1 for MUL if bits above W of the product are nonzero; 0 otherwise.
REQ-020 The FSM SHALL have states IDLE, BUSY, DONE.
REQ-021 InReady SHALL be 1 in IDLE, 1 in DONE while OutReady=1, and 0 in BUSY.
REQ-022 A single-cycle op accepted at edge k SHALL appear on Out/flags with OutValid=1 after edge k, i.e. latency 1; the state becomes DONE.
REQ-023 A MUL accepted at edge k SHALL enter BUSY and run a shift-add over W cycles, with OutValid=1 after edge k+W; the state becomes DONE.
REQ-024 In DONE with OutReady=0, Out, flags and OutValid SHALL hold unchanged and no input is accepted.
REQ-025 In DONE with OutReady=1 and InValid=1, the result SHALL be consumed and the new op accepted on the same edge, giving back-to-back throughput of 1 op/cycle for single-cycle ops.
REQ-026 In DONE with OutReady=1 and InValid=0, the FSM SHALL go to IDLE and OutValid SHALL fall; Out and flags hold their last values.
REQ-027 Operands, OP and SC_in SHALL be captured at accept; input changes during BUSY or DONE SHALL have no effect.
REQ-028 The MUL iteration counter SHALL be ceil(log2(W+1)) bits wide and SHALL NOT wrap during an operation.

Reset
REQ-029 Reset_n=0 SHALL immediately, without waiting for a clock edge, force IDLE, OutValid=0, Out=0, Zero=0, Parity=0, Odd=0, SC_out=0 and clear the MUL counter and accumulator.
REQ-030 InReady SHALL be 0 while Reset_n=0 and 1 from the first edge after Reset_n is released.
REQ-031 Reset during BUSY or DONE SHALL discard the in-flight operation; no OutValid pulse is produced for it.

Verification (W=8)
REQ-032 The bench SHALL check ADD: A=0xF0, B=0x20 -> Out=0x10, SC_out=1, Zero=0, Parity=1, Odd=0, OutValid 1 cycle after accept.
REQ-033 The bench SHALL check SUB: A=4, B=4 -> Out=0x00, Zero=1, SC_out=0; then A=1, B=4 -> Out=0xFD, SC_out=1, Odd=1.
REQ-034 The bench SHALL check shifts: SHL with A=0x81, B=1 -> Out=0x02, SC_out=1; SHR with A=0x81, B=9 -> Out=0x00, Zero=1, SC_out=0; EQ with A=4, B=4 -> Out=0x01.
REQ-035 The bench SHALL check MUL: A=13, B=11 -> InReady=0 for 8 cycles, then Out=0x8F, SC_out=0; A=20, B=20 -> Out=0x90, SC_out=1.
REQ-036 The bench SHALL check backpressure: OutReady=0 for 5 cycles after an ADD result -> Out, flags and OutValid stable and InReady=0; then OutReady=1 with InValid=1 for XOR -> the next result is valid on the following cycle.
REQ-037 The bench SHALL check reset mid-op: Reset_n=0 at 3 cycles into a MUL -> OutValid=0 and Out=0 immediately; after release, an ADD of 4+1 -> Out=0x05.
